// File: rtl/axi4_s_rd_burst_ctrl_if.sv
// Signal bundle between the read burst sequencer, the AR/R FIFO pair and the backing memory.
interface axi4_s_rd_burst_ctrl_if #(
    parameter int unsigned A = 32,
    parameter int unsigned N = 8,
    parameter int unsigned I = 1
);
    logic             ar_rd_empty;
    logic             ar_rd_en;
    logic [I-1:0]     ar_id;
    logic [A-1:0]     ar_addr;
    logic [7:0]       ar_len;
    logic [2:0]       ar_size;
    logic [1:0]       ar_burst;

    logic             r_wr_full;
    logic             r_wr_en;
    logic [I-1:0]     r_id;
    logic [8*N-1:0]   r_data;
    logic [1:0]       r_resp;
    logic             r_last;

    logic             mem_rd_en;
    logic [A-1:0]     mem_addr;
    logic [8*N-1:0]   mem_rdata;

    modport slave (
        input  ar_rd_empty, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_rd_en,
        input  r_wr_full,
        output r_wr_en, r_id, r_data, r_resp, r_last,
        output mem_rd_en, mem_addr,
        input  mem_rdata
    );

    modport master (
        output ar_rd_empty, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_rd_en,
        output r_wr_full,
        input  r_wr_en, r_id, r_data, r_resp, r_last,
        input  mem_rd_en, mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/axi4_s_rd_burst_ctrl.sv
// AXI4 slave read sequencer: pops one AR request, walks FIXED/INCR/WRAP addresses,
// reads a one-cycle-latency memory per beat and pushes each beat into the R FIFO.
module axi4_s_rd_burst_ctrl #(
    parameter int unsigned A = 32,
    parameter int unsigned N = 8,
    parameter int unsigned I = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axi4_s_rd_burst_ctrl_if.slave bus
);
    localparam int unsigned DW = 8 * N;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlvErr = 2'd2;
    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstWrap  = 2'd2;
    localparam logic [1:0] BurstRsvd  = 2'd3;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StStall, StErr} state_e;

    state_e          state_q, state_d;
    logic            rdy_q;
    logic [I-1:0]    id_q, id_d;
    logic [A-1:0]    addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [DW-1:0]   hold_q, hold_d;

    logic [A-1:0]    step;
    logic [A-1:0]    wrap_mask;
    logic [A-1:0]    next_addr;
    logic [A-1:0]    ar_align_mask;
    logic            wrap_len_ok;
    logic            illegal;
    logic            last_beat;

    always_comb begin
        step      = A'(1) << size_q;
        wrap_mask = ((A'(len_q) + A'(1)) << size_q) - A'(1);
        case (burst_q)
            BurstFixed: next_addr = addr_q;
            BurstWrap:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default:    next_addr = addr_q + step;
        endcase
    end

    always_comb begin
        ar_align_mask = (A'(1) << bus.ar_size) - A'(1);
        wrap_len_ok   = bus.ar_len inside {8'd1, 8'd3, 8'd7, 8'd15};
        illegal       = (bus.ar_burst == BurstRsvd) ||
                        ((bus.ar_burst == BurstWrap) &&
                         (!wrap_len_ok || ((bus.ar_addr & ar_align_mask) != '0)));
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        hold_d  = hold_q;

        bus.ar_rd_en  = 1'b0;
        bus.r_wr_en   = 1'b0;
        bus.r_id      = id_q;
        bus.r_data    = '0;
        bus.r_resp    = RespOkay;
        bus.r_last    = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        last_beat     = (cnt_q == 8'd0);

        unique case (state_q)
            StIdle: begin
                // rdy_q keeps the pop low during and right after reset
                if (rdy_q && !bus.ar_rd_empty) begin
                    bus.ar_rd_en = 1'b1;
                    id_d         = bus.ar_id;
                    addr_d       = bus.ar_addr;
                    len_d        = bus.ar_len;
                    cnt_d        = bus.ar_len;
                    size_d       = bus.ar_size;
                    burst_d      = bus.ar_burst;
                    state_d      = illegal ? StErr : StIssue;
                end
            end
            StIssue: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = addr_q;
                state_d       = StWait;
            end
            StWait: begin
                if (bus.r_wr_full) begin
                    hold_d  = bus.mem_rdata;
                    state_d = StStall;
                end else begin
                    bus.r_wr_en = 1'b1;
                    bus.r_data  = bus.mem_rdata;
                    bus.r_last  = last_beat;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        // Pipelined: next beat is read while this one is pushed
                        addr_d        = next_addr;
                        cnt_d         = cnt_q - 8'd1;
                        bus.mem_rd_en = 1'b1;
                        bus.mem_addr  = next_addr;
                    end
                end
            end
            StStall: begin
                if (!bus.r_wr_full) begin
                    bus.r_wr_en = 1'b1;
                    bus.r_data  = hold_q;
                    bus.r_last  = last_beat;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q - 8'd1;
                        state_d = StIssue;
                    end
                end
            end
            StErr: begin
                if (!bus.r_wr_full) begin
                    bus.r_wr_en = 1'b1;
                    bus.r_resp  = RespSlvErr;
                    bus.r_last  = last_beat;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            rdy_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: tb/tb_axi4_s_rd_burst_ctrl.sv
// Bench for axi4_s_rd_burst_ctrl: table of bursts plus backpressure, back-to-back and reset sequences,
// with a scoreboard of expected memory addresses and R beats.
module tb_axi4_s_rd_burst_ctrl;
    localparam int unsigned A  = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned I  = 1;
    localparam int unsigned DW = 8 * N;

    typedef struct {
        logic [I-1:0] id;
        logic [A-1:0] addr;
        logic [7:0]   len;
        logic [2:0]   size;
        logic [1:0]   burst;
    } ar_t;

    typedef struct {
        logic [I-1:0]  id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    typedef struct {
        ar_t               req;
        int                nbeats;
        logic [1:0]        resp;
        int                naddr;
        logic [3:0][A-1:0] a;
    } vec_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    axi4_s_rd_burst_ctrl_if #(.A(A), .N(N), .I(I)) bus ();

    axi4_s_rd_burst_ctrl #(.A(A), .N(N), .I(I)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_pop = 0;
    int          popped = 0;
    ar_t         ar_q[$];
    beat_t       exp_r[$];
    logic [A-1:0] exp_a[$];
    logic [A-1:0] obs_a[$];
    int          pop_cyc[$];
    int          last_cyc[$];
    int          n_push, n_issue, first_mem, first_push;
    logic [1:0]  first_resp;
    beat_t       mon_e;
    vec_t        vt[8];

    function automatic logic [DW-1:0] mem_word(input logic [A-1:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic vec_t mk(input logic [I-1:0] id, input logic [A-1:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst, input int nbeats, input logic [1:0] resp,
                                input int naddr, input logic [A-1:0] a0, input logic [A-1:0] a1,
                                input logic [A-1:0] a2, input logic [A-1:0] a3);
        vec_t v;
        v.req.id = id; v.req.addr = addr; v.req.len = len; v.req.size = size; v.req.burst = burst;
        v.nbeats = nbeats; v.resp = resp; v.naddr = naddr;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail1(input string name, input logic [DW-1:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    // Independent address model: wrap offset taken modulo the wrap window
    task automatic queue_burst(input ar_t r);
        int           beats;
        logic [A-1:0] step, wb, base, a;
        bit           bad;
        beat_t        b;
        beats = int'(r.len) + 1;
        step  = 32'd1 << r.size;
        wb    = A'(beats) * step;
        base  = r.addr - (r.addr % wb);
        bad   = (r.burst == 2'd3) ||
                (r.burst == 2'd2 && !(r.len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                (r.burst == 2'd2 && (r.addr % step) != 0);
        for (int i = 0; i < beats; i++) begin
            case (r.burst)
                2'd0:    a = r.addr;
                2'd2:    a = base + (((r.addr - base) + A'(i) * step) % wb);
                default: a = r.addr + A'(i) * step;
            endcase
            b.id   = r.id;
            b.last = (i == beats - 1);
            if (bad) begin
                b.data = '0;
                b.resp = 2'd2;
            end else begin
                exp_a.push_back(a);
                b.data = mem_word(a);
                b.resp = 2'd0;
            end
            exp_r.push_back(b);
        end
        ar_q.push_back(r);
    endtask

    task automatic clr_stats();
        obs_a.delete();
        pop_cyc.delete();
        last_cyc.delete();
        n_push = 0;
        n_issue = 0;
        first_mem = -1;
        first_push = -1;
        first_resp = 2'd3;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_r.size() != 0 || ar_q.size() != 0) && k < 400) begin
            @(negedge aclk);
            k++;
        end
        if (k >= 400) begin
            fail1("wait_done_timeout", 64'(exp_r.size()));
            exp_r.delete();
            exp_a.delete();
        end
        repeat (3) @(negedge aclk);
    endtask

    // Memory with one-cycle read latency
    always @(posedge aclk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem_word(bus.mem_addr);
    end

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus.ar_rd_en) begin
                chk("ar_pop_nonempty", 64'(bus.ar_rd_empty), 64'd0);
                n_pop++;
                pop_cyc.push_back(cyc);
            end
            if (bus.mem_rd_en) begin
                n_issue++;
                obs_a.push_back(bus.mem_addr);
                if (first_mem < 0) first_mem = cyc;
                if (exp_a.size() == 0) fail1("mem_rd_unexpected", 64'(bus.mem_addr));
                else chk("mem_addr", 64'(bus.mem_addr), 64'(exp_a.pop_front()));
            end
            if (bus.r_wr_en) begin
                chk("push_while_full", 64'(bus.r_wr_full), 64'd0);
                n_push++;
                if (first_push < 0) begin
                    first_push = cyc;
                    first_resp = bus.r_resp;
                end
                if (bus.r_last) last_cyc.push_back(cyc);
                if (exp_r.size() == 0) begin
                    fail1("push_unexpected", bus.r_data);
                end else begin
                    mon_e = exp_r.pop_front();
                    chk("r_id", 64'(bus.r_id), 64'(mon_e.id));
                    chk("r_data", bus.r_data, mon_e.data);
                    chk("r_resp", 64'(bus.r_resp), 64'(mon_e.resp));
                    chk("r_last", 64'(bus.r_last), 64'(mon_e.last));
                end
            end
        end
    end

    // Show-ahead AR FIFO model
    initial begin
        bus.ar_rd_empty = 1'b1;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
        forever begin
            @(posedge aclk);
            #1;
            while (popped < n_pop) begin
                if (ar_q.size() > 0) void'(ar_q.pop_front());
                popped++;
            end
            if (ar_q.size() == 0) begin
                bus.ar_rd_empty = 1'b1;
            end else begin
                bus.ar_rd_empty = 1'b0;
                bus.ar_id       = ar_q[0].id;
                bus.ar_addr     = ar_q[0].addr;
                bus.ar_len      = ar_q[0].len;
                bus.ar_size     = ar_q[0].size;
                bus.ar_burst    = ar_q[0].burst;
            end
        end
    end

    initial begin
        ar_t rq;
        int  k;

        vt[0] = mk(1'b0, 32'h100, 8'd3, 3'd3, 2'd1, 4, 2'd0, 4,
                   32'h100, 32'h108, 32'h110, 32'h118);
        vt[1] = mk(1'b1, 32'h38, 8'd3, 3'd3, 2'd2, 4, 2'd0, 4,
                   32'h38, 32'h20, 32'h28, 32'h30);
        vt[2] = mk(1'b0, 32'h40, 8'd2, 3'd3, 2'd0, 3, 2'd0, 3,
                   32'h40, 32'h40, 32'h40, 32'h0);
        vt[3] = mk(1'b1, 32'h10, 8'd1, 3'd3, 2'd3, 2, 2'd2, 0, 0, 0, 0, 0);
        vt[4] = mk(1'b0, 32'h30, 8'd2, 3'd3, 2'd2, 3, 2'd2, 0, 0, 0, 0, 0);
        vt[5] = mk(1'b1, 32'h34, 8'd3, 3'd3, 2'd2, 4, 2'd2, 0, 0, 0, 0, 0);
        vt[6] = mk(1'b0, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'd1, 2, 2'd0, 2,
                   32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
        vt[7] = mk(1'b1, 32'h4, 8'd0, 3'd2, 2'd1, 1, 2'd0, 1, 32'h4, 0, 0, 0);

        bus.r_wr_full = 1'b0;
        clr_stats();
        // A request is already waiting while reset is held
        rq.id = 1'b1; rq.addr = 32'h80; rq.len = 8'd0; rq.size = 3'd3; rq.burst = 2'd1;
        queue_burst(rq);
        repeat (3) @(negedge aclk);
        chk("rst_ar_rd_en", 64'(bus.ar_rd_en), 64'd0);
        chk("rst_r_wr_en", 64'(bus.r_wr_en), 64'd0);
        chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("rst_r_last", 64'(bus.r_last), 64'd0);
        chk("rst_r_id", 64'(bus.r_id), 64'd0);
        chk("rst_r_data", bus.r_data, 64'd0);
        chk("rst_r_resp", 64'(bus.r_resp), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        aresetn = 1'b1;
        wait_done();
        chk("post_rst_push_count", 64'(n_push), 64'd1);

        for (int r = 0; r < 8; r++) begin
            clr_stats();
            queue_burst(vt[r].req);
            wait_done();
            chk($sformatf("row%0d_push_count", r), 64'(n_push), 64'(vt[r].nbeats));
            chk($sformatf("row%0d_resp", r), 64'(first_resp), 64'(vt[r].resp));
            chk($sformatf("row%0d_issue_count", r), 64'(n_issue),
                64'((vt[r].resp == 2'd0) ? vt[r].nbeats : 0));
            for (int j = 0; j < vt[r].naddr; j++) begin
                if (j < obs_a.size()) chk($sformatf("row%0d_addr%0d", r, j), 64'(obs_a[j]), 64'(vt[r].a[j]));
                else fail1($sformatf("row%0d_addr%0d_missing", r, j), 64'(obs_a.size()));
            end
            if (vt[r].resp == 2'd0 && pop_cyc.size() > 0 && last_cyc.size() > 0) begin
                chk($sformatf("row%0d_lat_mem", r), 64'(first_mem - pop_cyc[0]), 64'd1);
                chk($sformatf("row%0d_lat_push", r), 64'(first_push - pop_cyc[0]), 64'd2);
                chk($sformatf("row%0d_lat_last", r), 64'(last_cyc[0] - pop_cyc[0]),
                    64'(int'(vt[r].req.len) + 2));
            end
        end

        // Backpressure: R full for 3 cycles while beat 2 data is on mem_rdata
        clr_stats();
        rq.id = 1'b0; rq.addr = 32'h200; rq.len = 8'd7; rq.size = 3'd3; rq.burst = 2'd1;
        queue_burst(rq);
        k = 0;
        while (n_issue < 3 && k < 50) begin
            @(negedge aclk);
            #1;
            k++;
        end
        if (k >= 50) fail1("bp_issue_timeout", 64'(n_issue));
        @(posedge aclk);
        #1 bus.r_wr_full = 1'b1;
        repeat (3) @(posedge aclk);
        #1 bus.r_wr_full = 1'b0;
        wait_done();
        chk("bp_push_count", 64'(n_push), 64'd8);
        chk("bp_issue_count", 64'(n_issue), 64'd8);
        if (pop_cyc.size() > 0 && last_cyc.size() > 0)
            chk("bp_total_cycles", 64'(last_cyc[0] - pop_cyc[0]), 64'd13);
        else fail1("bp_no_last", 64'(last_cyc.size()));

        // Back-to-back requests: second pop only after first r_last
        clr_stats();
        rq.id = 1'b0; rq.addr = 32'h300; rq.len = 8'd1; rq.size = 3'd3; rq.burst = 2'd1;
        queue_burst(rq);
        rq.id = 1'b1; rq.addr = 32'h400; rq.len = 8'd2; rq.size = 3'd2; rq.burst = 2'd1;
        queue_burst(rq);
        wait_done();
        chk("b2b_pop_count", 64'(pop_cyc.size()), 64'd2);
        chk("b2b_push_count", 64'(n_push), 64'd5);
        if (pop_cyc.size() == 2 && last_cyc.size() > 0)
            chk("b2b_pop_after_last", 64'(pop_cyc[1] > last_cyc[0]), 64'd1);
        else fail1("b2b_missing_events", 64'(pop_cyc.size()));

        // Reset mid-burst
        clr_stats();
        rq.id = 1'b1; rq.addr = 32'h500; rq.len = 8'd7; rq.size = 3'd3; rq.burst = 2'd1;
        queue_burst(rq);
        k = 0;
        while (n_push < 2 && k < 50) begin
            @(negedge aclk);
            #1;
            k++;
        end
        if (k >= 50) fail1("rst_mid_timeout", 64'(n_push));
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_r_wr_en", 64'(bus.r_wr_en), 64'd0);
        chk("mid_rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("mid_rst_r_data", bus.r_data, 64'd0);
        chk("mid_rst_r_last", 64'(bus.r_last), 64'd0);
        chk("mid_rst_r_id", 64'(bus.r_id), 64'd0);
        chk("mid_rst_ar_rd_en", 64'(bus.ar_rd_en), 64'd0);
        exp_r.delete();
        exp_a.delete();
        repeat (2) @(negedge aclk);
        #2 aresetn = 1'b1;
        clr_stats();
        rq.id = 1'b0; rq.addr = 32'h600; rq.len = 8'd2; rq.size = 3'd3; rq.burst = 2'd1;
        queue_burst(rq);
        wait_done();
        chk("after_rst_push_count", 64'(n_push), 64'd3);
        if (pop_cyc.size() > 0 && last_cyc.size() > 0)
            chk("after_rst_lat_last", 64'(last_cyc[0] - pop_cyc[0]), 64'd4);
        else fail1("after_rst_no_last", 64'(last_cyc.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
